// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared owner encoding, strobe width and owner-entry type for the memory port arbiter
package mem_pkg;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_D   = 1'b1;
  localparam int   WSTRB_W = 4;

  // One outstanding access: in flight, who issued it, and whether it was a store
  typedef struct packed {
    logic valid;
    logic owner;
    logic store;
  } own_entry_t;

endpackage

// File: rtl/resp_tracker.sv
// rtl/resp_tracker.sv - LATENCY-deep owner shift register steering memory read data to its requester
module resp_tracker
  import mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  own_entry_t  i_push,
  input  logic [31:0] i_mem_rdata,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata
);

  own_entry_t r_pipe [LATENCY];
  own_entry_t w_tail;

  // Age every grant by one stage per cycle; reset discards anything in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_push;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tail = r_pipe[LATENCY-1];

  // The tail entry lines up with the cycle in which the memory presents its read data
  assign o_if_rvalid = w_tail.valid && (w_tail.owner == OWN_IF);
  assign o_d_rvalid  = w_tail.valid && (w_tail.owner == OWN_D);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_d_rdata   = (o_d_rvalid && !w_tail.store) ? i_mem_rdata : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the single-port memory with bounded fetch starvation
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int LATENCY  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [31:0]        if_rdata,
  input  logic               d_req,
  input  logic [31:0]        d_addr,
  input  logic               d_wen,
  input  logic [31:0]        d_wdata,
  input  logic [WSTRB_W-1:0] d_wstrb,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [31:0]        d_rdata,
  output logic               mem_en,
  output logic [31:0]        mem_addr,
  output logic               mem_wen,
  output logic [31:0]        mem_wdata,
  output logic [WSTRB_W-1:0] mem_wstrb,
  input  logic [31:0]        mem_rdata
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic       [3:0] r_starve_cnt;
  logic             w_sat;
  logic             w_if_win;
  logic             w_d_win;
  own_entry_t       w_push;

  // Data normally wins; fetch takes the port once it has lost MAX_WAIT times in a row.
  // Gating with reset_n keeps every combinational output at 0 while in reset.
  assign w_sat    = (r_starve_cnt == MAX_W);
  assign w_if_win = reset_n && if_req && (!d_req || w_sat);
  assign w_d_win  = reset_n && d_req && !w_if_win;

  assign if_gnt    = w_if_win;
  assign d_gnt     = w_d_win;
  assign mem_en    = w_if_win || w_d_win;
  assign mem_addr  = w_if_win ? if_addr : (w_d_win ? d_addr : '0);
  assign mem_wen   = w_d_win && d_wen;
  assign mem_wdata = w_d_win ? d_wdata : '0;
  assign mem_wstrb = w_d_win ? d_wstrb : '0;

  // Count consecutive conflicts lost by fetch; any fetch grant restarts the count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (w_if_win) begin
      r_starve_cnt <= '0;
    end else if (if_req && w_d_win && (r_starve_cnt != MAX_W)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Describe this cycle's grant for the response tracker
  always_comb begin
    w_push       = '0;
    w_push.valid = w_if_win || w_d_win;
    w_push.owner = w_d_win ? OWN_D : OWN_IF;
    w_push.store = w_d_win && d_wen;
  end

  resp_tracker #(
    .LATENCY(LATENCY)
  ) u_resp_tracker (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_push      (w_push),
    .i_mem_rdata (mem_rdata),
    .o_if_rvalid (if_rvalid),
    .o_if_rdata  (if_rdata),
    .o_d_rvalid  (d_rvalid),
    .o_d_rdata   (d_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter at LATENCY 1 and 2
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_wen;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] mem_rdata;

  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_wen;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        if_gnt2, if_rvalid2, d_gnt2, d_rvalid2, mem_en2, mem_wen2;
  logic [31:0] if_rdata2, d_rdata2, mem_addr2, mem_wdata2;
  logic [3:0]  mem_wstrb2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.LATENCY(1), .MAX_WAIT(4)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.LATENCY(2), .MAX_WAIT(4)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt2), .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .mem_en(mem_en2), .mem_addr(mem_addr2), .mem_wen(mem_wen2), .mem_wdata(mem_wdata2),
    .mem_wstrb(mem_wstrb2), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, checks follow after #3
  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic exp_if;
    logic prev_if;
    int   n_ifv;
    int   n_dv;

    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_addr = '0;
    d_wen = 1'b0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;

    // Reset state, including requests presented while in reset
    #2;
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    if_req = 1'b1; d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h8; d_wdata = 32'h5; d_wstrb = 4'hF; if_addr = 32'h4;
    #1;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    if_req = 1'b0; d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0; if_addr = '0;

    // Fetch alone, granted in the first cycle out of reset
    nxt();
    reset_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    #3;
    chk("f_if_gnt", if_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    chk("f_mem_en", mem_en, 1);
    chk("f_mem_addr", mem_addr, 32'h10);
    chk("f_mem_wen", mem_wen, 0);
    nxt();
    if_req = 1'b0; mem_rdata = 32'h00500093;
    #3;
    chk("f_if_rvalid", if_rvalid, 1);
    chk("f_if_rdata", if_rdata, 32'h00500093);
    chk("f_d_rvalid", d_rvalid, 0);
    chk("f_mem_en_idle", mem_en, 0);

    // Store completion: zero data even though memory drives something
    nxt();
    mem_rdata = 32'h12345678;
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    #3;
    chk("s_d_gnt", d_gnt, 1);
    chk("s_mem_wen", mem_wen, 1);
    chk("s_mem_addr", mem_addr, 32'h40);
    chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("s_mem_wstrb", mem_wstrb, 4'hF);
    chk("s_if_rvalid", if_rvalid, 0);
    nxt();
    d_req = 1'b0; d_wen = 1'b0; d_wdata = '0; d_wstrb = '0;
    #3;
    chk("s_d_rvalid", d_rvalid, 1);
    chk("s_d_rdata", d_rdata, 0);
    chk("s_if_rvalid2", if_rvalid, 0);

    // Starvation: both requesting continuously, expect D,D,D,D,IF,D,D,D,D,IF
    nxt();
    if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h80;
    prev_if = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_if = (k == 4) || (k == 9);
      #3;
      chk($sformatf("sv_if_gnt[%0d]", k), if_gnt, exp_if);
      chk($sformatf("sv_d_gnt[%0d]", k), d_gnt, !exp_if);
      chk($sformatf("sv_addr[%0d]", k), mem_addr, exp_if ? 32'h20 : 32'h80);
      chk($sformatf("sv_cnt[%0d]", k), dut1.r_starve_cnt, (k < 5) ? k : k - 5);
      if (k > 0) begin
        chk($sformatf("sv_if_rv[%0d]", k), if_rvalid, prev_if);
        chk($sformatf("sv_d_rv[%0d]", k), d_rvalid, !prev_if);
      end
      prev_if = exp_if;
      nxt();
    end
    if_req = 1'b0; d_req = 1'b0;
    #3;
    chk("sv_cnt_clear", dut1.r_starve_cnt, 0);
    chk("sv_last_if_rv", if_rvalid, 1);

    // Request withdrawal: one-cycle fetch request that loses to a load
    nxt();
    if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_addr = 32'h84;
    #3;
    chk("w_d_gnt", d_gnt, 1);
    chk("w_if_gnt", if_gnt, 0);
    chk("w_mem_addr", mem_addr, 32'h84);
    nxt();
    if_req = 1'b0; d_req = 1'b0;
    #3;
    chk("w_mem_en", mem_en, 0);
    chk("w_cnt", dut1.r_starve_cnt, 1);
    chk("w_d_rvalid", d_rvalid, 1);
    chk("w_if_rvalid", if_rvalid, 0);
    nxt();
    #3;
    chk("w_if_rvalid_late", if_rvalid, 0);
    chk("w_cnt_hold", dut1.r_starve_cnt, 1);

    // Reset mid-operation: load granted on the LATENCY=2 instance, reset before its response
    nxt();
    d_req = 1'b1; d_addr = 32'h50;
    #3;
    chk("r_d_gnt2", d_gnt2, 1);
    nxt();
    reset_n = 1'b0;
    #3;
    chk("r_d_gnt2_rst", d_gnt2, 0);
    chk("r_mem_en2_rst", mem_en2, 0);
    chk("r_mem_addr2_rst", mem_addr2, 0);
    chk("r_d_rvalid2_rst", d_rvalid2, 0);
    chk("r_d_rvalid1_rst", d_rvalid, 0);
    chk("r_cnt_rst", dut1.r_starve_cnt, 0);
    nxt();
    #3;
    chk("r_d_rvalid2_slot", d_rvalid2, 0);
    nxt();
    reset_n = 1'b1; d_req = 1'b0;
    #3;
    chk("r_d_rvalid2_post", d_rvalid2, 0);
    chk("r_d_rvalid1_post", d_rvalid, 0);
    nxt();
    d_req = 1'b1; d_addr = 32'h60; mem_rdata = 32'h0BADF00D;
    #3;
    chk("r_d_gnt_again", d_gnt, 1);
    chk("r_mem_addr_again", mem_addr, 32'h60);
    nxt();
    d_req = 1'b0;
    #3;
    chk("r_d_rvalid1_again", d_rvalid, 1);
    chk("r_d_rdata1_again", d_rdata, 32'h0BADF00D);
    chk("r_d_rvalid2_early", d_rvalid2, 0);
    nxt();
    #3;
    chk("r_d_rvalid2_again", d_rvalid2, 1);
    chk("r_d_rdata2_again", d_rdata2, 32'h0BADF00D);

    // Interleaved fetch 0x0 / load 0x44 every cycle on the LATENCY=2 instance
    nxt();
    #3;
    n_ifv = 0; n_dv = 0;
    for (int k = 0; k < 10; k++) begin
      nxt();
      if_req = (k < 8) && (k % 2 == 0);
      d_req  = (k < 8) && (k % 2 == 1);
      if_addr = 32'h0; d_addr = 32'h44; d_wen = 1'b0;
      mem_rdata = 32'hA0000000 + k;
      #3;
      if (k < 8) begin
        chk($sformatf("i_if_gnt[%0d]", k), if_gnt2, (k % 2 == 0));
        chk($sformatf("i_d_gnt[%0d]", k), d_gnt2, (k % 2 == 1));
        chk($sformatf("i_addr[%0d]", k), mem_addr2, (k % 2 == 0) ? 32'h0 : 32'h44);
      end
      exp_if = (k >= 2) && ((k - 2) % 2 == 0);
      chk($sformatf("i_if_rv[%0d]", k), if_rvalid2, exp_if);
      chk($sformatf("i_d_rv[%0d]", k), d_rvalid2, (k >= 2) && !exp_if);
      chk($sformatf("i_if_rd[%0d]", k), if_rdata2, exp_if ? 32'hA0000000 + k : 32'h0);
      chk($sformatf("i_d_rd[%0d]", k), d_rdata2, ((k >= 2) && !exp_if) ? 32'hA0000000 + k : 32'h0);
      if (if_rvalid2) n_ifv++;
      if (d_rvalid2) n_dv++;
    end
    chk("i_if_count", n_ifv, 4);
    chk("i_d_count", n_dv, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
